// File: rtl/shade_unit.sv
// Shading stage: buffers one fragment, forms N.L, clamps it to an intensity and scales the colour by ambient + intensity.
// Optional macro SHADE_SHADOW_ATTEN_EN: shadowed fragments keep only the ambient term.

package shade_pkg;
    localparam int SH_COLOR_W = 8;

    typedef enum logic [1:0] {
        ST_None     = 2'd0,
        ST_Diffuse  = 2'd1,
        ST_Specular = 2'd2
    } surface_t;

    typedef struct packed {
        logic [SH_COLOR_W-1:0] r;
        logic [SH_COLOR_W-1:0] g;
        logic [SH_COLOR_W-1:0] b;
    } color_t;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vec3_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] PI;
        logic [3:0]  BounceLevel;
        color_t      LastColor;
        color_t      Color;
        surface_t    SurfaceType;
        vec3_t       Normal;
        logic        bShadow;
    } ShadowOutputData;

    typedef struct packed {
        vec3_t                 LightDir;
        logic [SH_COLOR_W-1:0] Ambient;
    } RenderState;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] PI;
        logic [3:0]  BounceLevel;
        color_t      LastColor;
        color_t      Color;
        logic        bShadow;
    } ShadeOutputData;
endpackage

module shade_unit
    import shade_pkg::*;
#(
    parameter int NORM_FRAC = 14,
    parameter int COLOR_W   = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            add_input,
    input  ShadowOutputData input_data,
    input  RenderState      rs,
    input  logic            output_fifo_full,
    output logic            fifo_full,
    output logic            valid,
    output ShadeOutputData  out
);

    localparam int DOT_W   = 34;
    localparam int ONE_POS = 2 * NORM_FRAC;
    localparam logic signed [DOT_W-1:0] D_ONE = DOT_W'(1) << ONE_POS;

    typedef enum logic [1:0] {
        SHDS_Init = 2'd0,
        SHDS_Dot  = 2'd1,
        SHDS_Mul  = 2'd2,
        SHDS_Done = 2'd3
    } state_t;

    state_t                   state;
    ShadowOutputData          buf_q;
    ShadowOutputData          work_q;
    logic [7:0]               intensity_q;
    color_t                   shaded_q;

    logic signed [DOT_W-1:0]  dot_c;
    logic [7:0]               intensity_c;
    logic [7:0]               i_eff;
    logic [8:0]               s_c;
    color_t                   scaled_c;

    // min(max, (c*s)>>8); the shifted product exceeds max exactly when its top bit is set.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c, input logic [8:0] s);
        logic [COLOR_W+8:0] p;
        logic [COLOR_W+8:0] q;
        p = (COLOR_W+9)'(c) * (COLOR_W+9)'(s);
        q = p >> 8;
        return (|q[COLOR_W+8:COLOR_W]) ? '1 : q[COLOR_W-1:0];
    endfunction

    // NOTE: combinational blocks assign every output first, so no latch can be inferred.
    always_comb begin
        dot_c = DOT_W'(work_q.Normal.x) * DOT_W'(rs.LightDir.x)
              + DOT_W'(work_q.Normal.y) * DOT_W'(rs.LightDir.y)
              + DOT_W'(work_q.Normal.z) * DOT_W'(rs.LightDir.z);
        intensity_c = '0;
        if (dot_c <= 0)
            intensity_c = '0;
        else if (dot_c >= D_ONE)
            intensity_c = 8'hFF;
        else
            intensity_c = dot_c[ONE_POS-1 -: 8];
    end

`ifdef SHADE_SHADOW_ATTEN_EN
    assign i_eff = work_q.bShadow ? 8'd0 : intensity_q;
`else
    assign i_eff = intensity_q;
`endif

    assign s_c = {1'b0, rs.Ambient} + {1'b0, i_eff};

    always_comb begin
        scaled_c   = '0;
        scaled_c.r = scale(work_q.Color.r, s_c);
        scaled_c.g = scale(work_q.Color.g, s_c);
        scaled_c.b = scale(work_q.Color.b, s_c);
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath registers are
    // cleared on reset too so a discarded fragment can never leak into out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= SHDS_Init;
            fifo_full   <= 1'b0;
            valid       <= 1'b0;
            out         <= '0;
            buf_q       <= '0;
            work_q      <= '0;
            intensity_q <= '0;
            shaded_q    <= '0;
        end else begin
            valid <= 1'b0;

            // Acceptance needs an empty buffer and the Init hand-off needs a full one,
            // so the two writes to fifo_full never collide.
            if (add_input && !fifo_full) begin
                buf_q     <= input_data;
                fifo_full <= 1'b1;
            end

            case (state)
                SHDS_Init: begin
                    if (fifo_full) begin
                        work_q    <= buf_q;
                        fifo_full <= 1'b0;
                        state     <= SHDS_Dot;
                    end
                end
                SHDS_Dot: begin
                    intensity_q <= intensity_c;
                    state       <= SHDS_Mul;
                end
                SHDS_Mul: begin
                    shaded_q <= (work_q.SurfaceType == ST_None) ? work_q.Color : scaled_c;
                    state    <= SHDS_Done;
                end
                SHDS_Done: begin
                    if (!output_fifo_full) begin
                        out <= '{x:           work_q.x,
                                 y:           work_q.y,
                                 PI:          work_q.PI,
                                 BounceLevel: work_q.BounceLevel,
                                 LastColor:   work_q.LastColor,
                                 Color:       shaded_q,
                                 bShadow:     work_q.bShadow};
                        valid <= 1'b1;
                        state <= SHDS_Init;
                    end
                end
                default: state <= SHDS_Init;
            endcase
        end
    end

endmodule

// File: tb/tb_shade_unit.sv
// Self-checking bench for shade_unit: directed vector table, reset/backpressure sequences,
// and a randomized stream scored against an arithmetic reference model.

module tb_shade_unit;
    import shade_pkg::*;

    localparam int NF = 14;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            add_input = 1'b0;
    logic            output_fifo_full = 1'b0;
    ShadowOutputData input_data = '0;
    RenderState      rs = '0;
    logic            fifo_full;
    logic            valid;
    ShadeOutputData  out;

    shade_unit #(.NORM_FRAC(NF), .COLOR_W(8)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .add_input        (add_input),
        .input_data       (input_data),
        .rs               (rs),
        .output_fifo_full (output_fifo_full),
        .fifo_full        (fifo_full),
        .valid            (valid),
        .out              (out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int chan(input logic [7:0] c, input int s);
        int v;
        v = (int'(c) * s) / 256;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic color_t ref_color(input ShadowOutputData f, input RenderState r);
        longint d;
        int     i;
        int     s;
        color_t c;
        if (f.SurfaceType == ST_None) return f.Color;
        d = longint'(f.Normal.x) * longint'(r.LightDir.x)
          + longint'(f.Normal.y) * longint'(r.LightDir.y)
          + longint'(f.Normal.z) * longint'(r.LightDir.z);
        if (d <= 0)                            i = 0;
        else if (d >= (longint'(1) << (2*NF))) i = 255;
        else                                   i = int'(d / (longint'(1) << (2*NF - 8)));
`ifdef SHADE_SHADOW_ATTEN_EN
        if (f.bShadow) i = 0;
`endif
        s = int'(r.Ambient) + i;
        c.r = 8'(chan(f.Color.r, s));
        c.g = 8'(chan(f.Color.g, s));
        c.b = 8'(chan(f.Color.b, s));
        return c;
    endfunction

    function automatic ShadeOutputData expect_out(input ShadowOutputData f, input RenderState r);
        ShadeOutputData o;
        o.x = f.x; o.y = f.y; o.PI = f.PI; o.BounceLevel = f.BounceLevel;
        o.LastColor = f.LastColor; o.bShadow = f.bShadow;
        o.Color = ref_color(f, r);
        return o;
    endfunction

    function automatic ShadowOutputData mk_frag(input int x, input int y, input int pi, input surface_t st,
                                                input int nx, input int ny, input int nz,
                                                input int cr, input int cg, input int cb, input bit sh);
        ShadowOutputData f;
        f = '0;
        f.x = 16'(x); f.y = 16'(y); f.PI = 16'(pi); f.BounceLevel = 4'(pi);
        f.SurfaceType = st;
        f.Normal.x = 16'(nx); f.Normal.y = 16'(ny); f.Normal.z = 16'(nz);
        f.Color.r = 8'(cr); f.Color.g = 8'(cg); f.Color.b = 8'(cb);
        f.LastColor = ~f.Color;
        f.bShadow = sh;
        return f;
    endfunction

    function automatic RenderState mk_rs(input int lx, input int ly, input int lz, input int amb);
        RenderState r;
        r.LightDir.x = 16'(lx); r.LightDir.y = 16'(ly); r.LightDir.z = 16'(lz);
        r.Ambient = 8'(amb);
        return r;
    endfunction

    function automatic int rand_comp();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 32768)) - 16384;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic ShadowOutputData rand_frag();
        return mk_frag(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 65535)), surface_t'($urandom_range(0, 2)),
                       rand_comp(), rand_comp(), rand_comp(),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    endfunction

    // ---------------- drivers (all driven #1 after a rising edge) ----------------
    task automatic send(input ShadowOutputData f);
        int w;
        w = 0;
        while (fifo_full && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (fifo_full) check("buffer_free_timeout", 128'(fifo_full), 128'(0));
        input_data = f;
        add_input  = 1'b1;
        @(posedge clk); #1;
        add_input  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid && lat < 30);
    endtask

    // ---------------- streaming scoreboard ----------------
    bit             stream_en = 1'b0;
    ShadeOutputData exp_q[$];

    always @(posedge clk)
        if (stream_en && resetn && add_input && !fifo_full)
            exp_q.push_back(expect_out(input_data, rs));

    always @(negedge clk)
        if (stream_en && valid) begin
            if (exp_q.size() == 0) check("stream_extra_valid", 128'(1), 128'(0));
            else                   check("stream_out", 128'(out), 128'(exp_q.pop_front()));
        end

    // ---------------- directed vector table ----------------
    typedef struct {
        string           name;
        ShadowOutputData frag;
        RenderState      rs;
        color_t          exp_color;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int             lat;
        int             nvalid;
        int             nempty;
        ShadeOutputData exp_o;
        ShadeOutputData exp_a;
        ShadeOutputData exp_b;
        ShadeOutputData held;
        ShadowOutputData fa;
        ShadowOutputData fb;
        RenderState     r0;

        vecs[0] = '{"lit",     mk_frag(1, 2, 3, ST_Diffuse, 0, 0, 16384, 200, 100, 50, 1'b0),
                    mk_rs(0, 0, 16384, 0),   '{8'd199, 8'd99, 8'd49}};
`ifdef SHADE_SHADOW_ATTEN_EN
        vecs[1] = '{"shadow",  mk_frag(4, 5, 6, ST_Diffuse, 0, 0, 16384, 200, 100, 50, 1'b1),
                    mk_rs(0, 0, 16384, 64),  '{8'd50, 8'd25, 8'd12}};
`else
        vecs[1] = '{"shadow",  mk_frag(4, 5, 6, ST_Diffuse, 0, 0, 16384, 200, 100, 50, 1'b1),
                    mk_rs(0, 0, 16384, 64),  '{8'd249, 8'd124, 8'd62}};
`endif
        vecs[2] = '{"backface", mk_frag(7, 8, 9, ST_Diffuse, 0, 0, -16384, 255, 255, 255, 1'b0),
                    mk_rs(0, 0, 16384, 128), '{8'd127, 8'd127, 8'd127}};
        vecs[3] = '{"sky",     mk_frag(100, 200, 300, ST_None, 1000, -2000, 3000, 10, 20, 30, 1'b1),
                    mk_rs(5000, 6000, -7000, 200), '{8'd10, 8'd20, 8'd30}};
        vecs[4] = '{"half",    mk_frag(11, 12, 13, ST_Specular, 0, 0, 8192, 255, 128, 2, 1'b0),
                    mk_rs(0, 0, 16384, 0),   '{8'd127, 8'd64, 8'd1}};
        vecs[5] = '{"amb_sat", mk_frag(14, 15, 16, ST_Diffuse, 0, 0, 16384, 1, 128, 255, 1'b0),
                    mk_rs(0, 0, 16384, 255), '{8'd1, 8'd255, 8'd255}};
        vecs[6] = '{"oblique", mk_frag(17, 18, 19, ST_Diffuse, 11585, 0, 11585, 255, 255, 255, 1'b0),
                    mk_rs(16384, 0, 0, 0),   '{8'd180, 8'd180, 8'd180}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_fifo_full", 128'(fifo_full), 128'(0));
        check("reset_valid",     128'(valid),     128'(0));
        check("reset_out",       128'(out),       128'(0));
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: latency and full output record
        for (int i = 0; i < 7; i++) begin
            rs = vecs[i].rs;
            send(vecs[i].frag);
            wait_valid(lat);
            exp_o = expect_out(vecs[i].frag, vecs[i].rs);
            exp_o.Color = vecs[i].exp_color;
            check({vecs[i].name, "_latency"}, 128'(lat), 128'(4));
            check({vecs[i].name, "_out"},     128'(out), 128'(exp_o));
            @(posedge clk); #1;
            check({vecs[i].name, "_pulse_width"}, 128'(valid), 128'(0));
        end

        // Randomized single fragments with per-fragment render state
        for (int i = 0; i < 20; i++) begin
            fa = rand_frag();
            rs = mk_rs(rand_comp(), rand_comp(), rand_comp(), int'($urandom_range(0, 255)));
            send(fa);
            wait_valid(lat);
            check("rand_latency", 128'(lat), 128'(4));
            check("rand_out",     128'(out), 128'(expect_out(fa, rs)));
        end

        // Backpressure: stall in Done, second fragment buffered during the stall
        r0 = mk_rs(3000, -4000, 12000, 40);
        rs = r0;
        fa = mk_frag(21, 22, 23, ST_Diffuse, 2000, -3000, 15000, 90, 180, 240, 1'b0);
        fb = mk_frag(31, 32, 33, ST_Diffuse, -1000, 500, 16000, 250, 60, 120, 1'b1);
        exp_a = expect_out(fa, r0);
        exp_b = expect_out(fb, r0);
        output_fifo_full = 1'b1;
        send(fa);
        repeat (3) @(posedge clk);
        #1;
        held = out;
        send(fb);
        nvalid = 0;
        nempty = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid)      nvalid++;
            if (!fifo_full) nempty++;
            @(posedge clk); #1;
        end
        check("stall_valid_pulses", 128'(nvalid), 128'(0));
        check("stall_fifo_empty",   128'(nempty), 128'(0));
        check("stall_out_held",     128'(out),    128'(held));
        output_fifo_full = 1'b0;
        wait_valid(lat);
        check("release_first_lat", 128'(lat), 128'(1));
        check("release_first_out", 128'(out), 128'(exp_a));
        wait_valid(lat);
        check("release_second_lat", 128'(lat), 128'(4));
        check("release_second_out", 128'(out), 128'(exp_b));

        // Reset while a fragment is in Mul and another sits in the buffer
        send(fa);
        @(posedge clk); #1;
        send(fb);
        check("pre_reset_buffered", 128'(fifo_full), 128'(1));
        resetn = 1'b0;
        #1;
        check("midreset_fifo_full", 128'(fifo_full), 128'(0));
        check("midreset_valid",     128'(valid),     128'(0));
        check("midreset_out",       128'(out),       128'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        check("post_reset_no_valid", 128'(nvalid), 128'(0));
        send(vecs[0].frag);
        rs = vecs[0].rs;
        wait_valid(lat);
        exp_o = expect_out(vecs[0].frag, vecs[0].rs);
        exp_o.Color = vecs[0].exp_color;
        check("post_reset_latency", 128'(lat), 128'(4));
        check("post_reset_out",     128'(out), 128'(exp_o));

        // Randomized stream with random offers and random downstream stalls
        rs = mk_rs(rand_comp(), rand_comp(), rand_comp(), int'($urandom_range(0, 255)));
        @(posedge clk); #1;
        stream_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            input_data       = rand_frag();
            add_input        = 1'($urandom_range(0, 1));
            output_fifo_full = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        add_input = 1'b0;
        output_fifo_full = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        stream_en = 1'b0;
        check("stream_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
